// File: rtl/alu_bit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit_sequencer_if
// Description : Command/result handshake bundle for the bit-serial ALU
//               sequencer. The sequencer attaches through the slave modport,
//               the command source/result consumer through master.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_bit_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_x;
    logic [WIDTH-1:0] res_y;
    logic             res_flag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_x, res_y, res_flag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_x, res_y, res_flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit_sequencer
// Description : Walks a WIDTH-bit operand pair LSB-first through an external
//               combinational 1-bit ALU slice and collects x/y result words.
//               Define ALU_CMP_REDUCE_EN to compute the res_flag reduction.
// Revision    : 1.0  initial release
// ============================================================================
module alu_bit_sequencer #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_bit_sequencer_if.slave bus,
    output logic [1:0]        alu_sel,
    output logic              alu_a,
    output logic              alu_b,
    input  wire logic         alu_x,
    input  wire logic         alu_y
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_x;
    logic [WIDTH-1:0] r_res_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_last        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Terminate on the explicit last index so non-power-of-2 widths stop early
                if (r_cnt == C_LAST) begin
                    w_last = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand bits are presented from registers; the slice answer is captured
    // at the end of the same cycle by shifting in from the MSB, so after
    // WIDTH shifts bit k holds the answer for operand bit k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res_x <= '0;
            r_res_y <= '0;
            alu_sel <= 2'b00;
            alu_a   <= 1'b0;
            alu_b   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= bus.cmd_a >> 1;
            r_b     <= bus.cmd_b >> 1;
            r_res_x <= '0;
            r_res_y <= '0;
            alu_sel <= bus.cmd_op;
            alu_a   <= bus.cmd_a[0];
            alu_b   <= bus.cmd_b[0];
        end else if (r_state == ST_RUN) begin
            r_res_x <= {alu_x, r_res_x[WIDTH-1:1]};
            r_res_y <= {alu_y, r_res_y[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            if (w_last) begin
                r_cnt <= '0;
                alu_a <= 1'b0;
                alu_b <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                alu_a <= r_a[0];
                alu_b <= r_b[0];
            end
        end
    end

    assign bus.res_x = r_res_x;
    assign bus.res_y = r_res_y;

`ifdef ALU_CMP_REDUCE_EN
    logic r_flag;

    // Equality starts true and is ANDed; greater-than and the y-OR start false
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (w_accept) begin
            r_flag <= (bus.cmd_op == 2'b10);
        end else if (r_state == ST_RUN) begin
            case (alu_sel)
                2'b10:   r_flag <= r_flag & alu_x;
                2'b11:   r_flag <= alu_x | (r_flag & (alu_a == alu_b));
                default: r_flag <= r_flag | alu_y;
            endcase
        end
    end

    assign bus.res_flag = r_flag;
`else
    assign bus.res_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_bit_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_bit_sequencer
// Description : Self-checking bench for alu_bit_sequencer (WIDTH=8 and WIDTH=5
//               instances) with a bench-side 1-bit slice and reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_bit_sequencer;

    localparam int W  = 8;
    localparam int W5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_bit_sequencer_if #(.WIDTH(W))  bus  ();
    alu_bit_sequencer_if #(.WIDTH(W5)) bus5 ();

    logic [1:0] alu_sel, alu_sel5;
    logic       alu_a, alu_b, alu_x, alu_y;
    logic       alu_a5, alu_b5, alu_x5, alu_y5;

    // Slice behaviour: returns {x, y}
    function automatic logic [1:0] slice(input logic [1:0] s, input logic a, input logic b);
        case (s)
            2'b00:   return {a ^ b, a & b};
            2'b01:   return {a ^ b, a & ~b};
            2'b10:   return {a == b, a & b};
            default: return {a & ~b, ~(a & b)};
        endcase
    endfunction

    assign {alu_x, alu_y}   = slice(alu_sel, alu_a, alu_b);
    assign {alu_x5, alu_y5} = slice(alu_sel5, alu_a5, alu_b5);

    alu_bit_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_x   (alu_x),
        .alu_y   (alu_y)
    );

    alu_bit_sequencer #(.WIDTH(W5)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus5),
        .alu_sel (alu_sel5),
        .alu_a   (alu_a5),
        .alu_b   (alu_b5),
        .alu_x   (alu_x5),
        .alu_y   (alu_y5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic flag_cfg(input logic f);
`ifdef ALU_CMP_REDUCE_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: word-level results from the slice rule, flag from arithmetic
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] x, output logic [W-1:0] y, output logic f);
        for (int i = 0; i < W; i++) {x[i], y[i]} = slice(op, a[i], b[i]);
        case (op)
            2'b10:   f = (a == b);
            2'b11:   f = (a > b);
            default: f = (y != '0);
        endcase
        f = flag_cfg(f);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 32'({bus.cmd_ready, bus.res_valid, bus.res_flag, alu_sel, alu_a, alu_b}),
              32'(7'b1000000));
        check({tag, "_res"}, 32'({bus.res_x, bus.res_y}), 32'(0));
    endtask

    task automatic drive_random_cmd();
        bus.cmd_op = 2'($urandom);
        bus.cmd_a  = W'($urandom);
        bus.cmd_b  = W'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the result handshake
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] ex, input logic [W-1:0] ey,
                           input logic ef, input int hold);
        int cyc;
        int bad;
        logic [W-1:0] la, lb;
        cyc = 0;
        while (!bus.cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge clk);
        la = a;
        lb = b;
        cyc = 1;
        bad = 0;
        while (!bus.res_valid && cyc <= 3 * W) begin
            // Operand changes and stray valids during RUN must be ignored
            bus.cmd_valid = 1'($urandom);
            drive_random_cmd();
            if (alu_sel !== op || alu_a !== la[0] || alu_b !== lb[0] || bus.cmd_ready !== 1'b0) bad++;
            la = la >> 1;
            lb = lb >> 1;
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        check({tag, "_run_bits"}, 32'(bad), 32'(0));
        check({tag, "_res_x"}, 32'(bus.res_x), 32'(ex));
        check({tag, "_res_y"}, 32'(bus.res_y), 32'(ey));
        check({tag, "_flag"}, 32'(bus.res_flag), 32'(ef));
        check({tag, "_done_ctl"}, 32'({bus.cmd_ready, alu_sel, alu_a, alu_b}), 32'({1'b0, op, 2'b00}));
        bus.res_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            drive_random_cmd();
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.res_x !== ex ||
                bus.res_y !== ey || bus.res_flag !== ef || alu_a !== 1'b0) bad++;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(bad), 32'(0));
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'($urandom);
        check({tag, "_release"}, 32'({bus.res_valid, bus.cmd_ready}), 32'(2'b01));
        check({tag, "_res_kept"}, 32'({bus.res_x, bus.res_y}), 32'({ex, ey}));
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         f;
        int           hold;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mx, my;
        logic         mf;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        int           cyc;

        tbl[0] = '{2'b00, 8'hA5, 8'h3C, 8'h99, 8'h24, 1'b1, 0};
        tbl[1] = '{2'b10, 8'h5A, 8'h5A, 8'hFF, 8'h5A, 1'b1, 0};
        tbl[2] = '{2'b10, 8'h5B, 8'h5A, 8'hFE, 8'h5A, 1'b0, 1};
        tbl[3] = '{2'b11, 8'h80, 8'h7F, 8'h80, 8'hFF, 1'b1, 5};
        tbl[4] = '{2'b11, 8'h7F, 8'h80, 8'h7F, 8'hFF, 1'b0, 0};
        tbl[5] = '{2'b01, 8'hF0, 8'h0F, 8'hFF, 8'hF0, 1'b1, 2};

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.res_ready  = 1'b0;
        bus5.cmd_valid = 1'b0;
        bus5.cmd_op    = 2'b00;
        bus5.cmd_a     = '0;
        bus5.cmd_b     = '0;
        bus5.res_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; entry 3 stalls in DONE and entry 4 follows back-to-back
        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].x, tbl[i].y, flag_cfg(tbl[i].f), tbl[i].hold);

        // Reset asserted while bit 3 is on the slice
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'hFF;
        bus.cmd_b     = 8'h0F;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_bit3", 32'({bus.res_valid, alu_a, alu_b}), 32'(3'b011));
        rst = 1'b1;
        #1;
        check_reset("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        run_cmd("after_rst", 2'b01, 8'hF0, 8'h0F, 8'hFF, 8'hF0, flag_cfg(1'b1), 0);

        // Randomised commands against the reference model
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = (n % 4 == 0) ? ra : W'($urandom);
            model(rop, ra, rb, mx, my, mf);
            run_cmd($sformatf("rnd%0d", n), rop, ra, rb, mx, my, mf, int'($urandom_range(0, 3)));
        end

        // Non-power-of-2 width: must stop after 5 bits, not at counter overflow
        check("w5_cmd_ready", 32'(bus5.cmd_ready), 32'(1));
        bus5.cmd_valid = 1'b1;
        bus5.cmd_op    = 2'b00;
        bus5.cmd_a     = 5'h1F;
        bus5.cmd_b     = 5'h01;
        @(negedge clk);
        bus5.cmd_valid = 1'b0;
        cyc = 1;
        while (!bus5.res_valid && cyc <= 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w5_latency", 32'(cyc), 32'(W5 + 1));
        check("w5_res_x", 32'(bus5.res_x), 32'(5'h1E));
        check("w5_res_y", 32'(bus5.res_y), 32'(5'h01));
        bus5.res_ready = 1'b1;
        @(negedge clk);
        check("w5_release", 32'({bus5.res_valid, bus5.cmd_ready}), 32'(2'b01));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
